// File: rtl/lab3_mem_line_responder_pkg.sv
// lab3_mem_line_responder_pkg
//   Shared types and constants for the lab3 16B line memory responder.
//   - Memory message type encodings follow the existing vc mem-msgs values.
//   - mem_req_16B_t / mem_resp_16B_t mirror the cache2mem line message layout.
//   - FSM state encoding and the random-stall LFSR seed.
//   The LFSR seed is only used when LAB3_MEM_LINE_RESPONDER_RANDOM_STALL_EN
//   is defined.

package lab3_mem_line_responder_pkg;

    // Message type encodings (vc mem-msgs)
    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
    localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

    // Reported in resp.test when the request type is not understood
    localparam logic [1:0] MEM_TEST_BAD_TYPE = 2'b11;

    // Seed for the optional random-stall LFSR
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Responder FSM states
    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_WAIT = 2'd1,
        STATE_RESP = 2'd2
    } state_t;

    // 16B line request
    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    // 16B line response
    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    // True for request types that overwrite the addressed line
    function automatic logic is_line_write(input logic [2:0] msg_type);
        return (msg_type == MEM_TYPE_WRITE) || (msg_type == MEM_TYPE_INIT);
    endfunction

    // True for any request type the responder understands
    function automatic logic is_known_type(input logic [2:0] msg_type);
        return (msg_type == MEM_TYPE_READ) || is_line_write(msg_type);
    endfunction

endpackage

// File: rtl/lab3_mem_line_array.sv
// lab3_mem_line_array
//   p_num_lines x 128b line storage: one synchronous write port and one
//   combinational read port. Contents are not reset.
//   Ports:
//     clk      in   clock
//     wr_en    in   write enable, commits wr_data at the rising edge
//     wr_idx   in   line index for the write
//     wr_data  in   128b line written
//     rd_idx   in   line index for the read
//     rd_data  out  128b line at rd_idx (combinational)

module lab3_mem_line_array #(
    parameter int unsigned p_num_lines = 256
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [$clog2(p_num_lines)-1:0] wr_idx,
    input  logic [127:0]                   wr_data,
    input  logic [$clog2(p_num_lines)-1:0] rd_idx,
    output logic [127:0]                   rd_data
);

    logic [127:0] lines_q [p_num_lines];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            lines_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = lines_q[rd_idx];
    end

endmodule

// File: rtl/lab3_mem_line_responder.sv
// lab3_mem_line_responder
//   Memory-side responder for the lab3 16B cache2mem line protocol. Accepts
//   one request at a time, reads/writes/inits one 16B line and returns the
//   response p_latency+1 cycles after the accept cycle. Higher address bits
//   wrap modulo p_num_lines*16; addr[3:0] is ignored.
//   Optional feature: define LAB3_MEM_LINE_RESPONDER_RANDOM_STALL_EN to add
//   LFSR-driven random stalls on memresp_val.
//   Ports:
//     clk          in   clock
//     reset        in   synchronous active-high reset
//     memreq_msg   in   line request (type, opaque, addr, len, data)
//     memreq_val   in   request valid
//     memreq_rdy   out  request ready (only in IDLE)
//     memresp_msg  out  line response (type, opaque, test, len, data)
//     memresp_val  out  response valid
//     memresp_rdy  in   response ready

module lab3_mem_line_responder
    import lab3_mem_line_responder_pkg::*;
#(
    parameter int unsigned p_num_lines = 256,
    parameter int unsigned p_latency   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  mem_req_16B_t  memreq_msg,
    input  logic          memreq_val,
    output logic          memreq_rdy,
    output mem_resp_16B_t memresp_msg,
    output logic          memresp_val,
    input  logic          memresp_rdy
);

    localparam int unsigned IDX_W = $clog2(p_num_lines);
    localparam logic [3:0]  LAT   = 4'(p_latency);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q,   cnt_d;
    mem_resp_16B_t resp_q,  resp_d;

    logic             accept;
    logic             stall;
    logic [IDX_W-1:0] line_idx;
    logic             arr_wr_en;
    logic [127:0]     arr_rd_data;

    // Address bits that never select a line; gathered so they count as read
    logic unused_addr_bits;
    always_comb begin
        unused_addr_bits = ^{memreq_msg.addr[31:4+IDX_W], memreq_msg.addr[3:0]};
    end

    always_comb begin
        line_idx = memreq_msg.addr[4+IDX_W-1:4];
        accept   = memreq_val && memreq_rdy;
    end

    //------------------------------------------------------------------
    // Optional random stall source
    //------------------------------------------------------------------
`ifdef LAB3_MEM_LINE_RESPONDER_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16/14/13/11, advances every cycle
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        stall  = lfsr_q[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        stall = 1'b0;
    end
`endif

    //------------------------------------------------------------------
    // Line storage
    //------------------------------------------------------------------
    lab3_mem_line_array #(
        .p_num_lines (p_num_lines)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_idx  (line_idx),
        .wr_data (memreq_msg.data),
        .rd_idx  (line_idx),
        .rd_data (arr_rd_data)
    );

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_IDLE;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    //------------------------------------------------------------------
    // FSM: next-state logic
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_IDLE: begin
                if (accept) begin
                    state_d = (p_latency == 0) ? STATE_RESP : STATE_WAIT;
                end
            end
            STATE_WAIT: begin
                if (cnt_q == LAT) begin
                    state_d = STATE_RESP;
                end
            end
            STATE_RESP: begin
                // Handshake uses the gated valid so a stalled cycle never retires
                if (memresp_val && memresp_rdy) begin
                    state_d = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // FSM: outputs and datapath
    //------------------------------------------------------------------
    always_comb begin
        // Held low during reset so no request is accepted (or array written)
        memreq_rdy  = (state_q == STATE_IDLE) && !reset;
        memresp_val = (state_q == STATE_RESP) && !reset && !stall;
        memresp_msg = resp_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        arr_wr_en = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    // The array is accessed in the accept cycle; the response
                    // is fully formed here and simply held until retired.
                    arr_wr_en       = is_line_write(memreq_msg.msg_type);
                    cnt_d           = 4'd1;
                    resp_d.msg_type = memreq_msg.msg_type;
                    resp_d.opaque   = memreq_msg.opaque;
                    resp_d.len      = memreq_msg.len;
                    resp_d.test     = is_known_type(memreq_msg.msg_type) ? 2'b00 : MEM_TEST_BAD_TYPE;
                    resp_d.data     = (memreq_msg.msg_type == MEM_TYPE_READ) ? arr_rd_data : '0;
                end
            end
            STATE_WAIT: begin
                cnt_d = (cnt_q == LAT) ? 4'd0 : cnt_q + 4'd1;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lab3_mem_line_responder.sv
module tb_lab3_mem_line_responder;
    import lab3_mem_line_responder_pkg::*;

    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    mem_req_16B_t  memreq_msg;
    logic          memreq_val;
    logic          memreq_rdy;
    mem_resp_16B_t memresp_msg;
    logic          memresp_val;
    logic          memresp_rdy;

    lab3_mem_line_responder #(
        .p_num_lines (256),
        .p_latency   (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    mem_resp_16B_t sb_q[$];
    logic [127:0]  model_mem [int unsigned];

    localparam logic [127:0] DATA_D0 = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
    localparam logic [127:0] DATA_A  = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] DATA_B  = 128'hcafe_f00d_a5a5_5a5a_ffff_0000_1234_5678;
    localparam logic [127:0] DATA_C  = 128'h0f0f_f0f0_1357_9bdf_2468_ace0_7777_8888;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: what the response should be, and the memory update
    function automatic mem_resp_16B_t model_resp(input mem_req_16B_t req);
        mem_resp_16B_t r;
        int unsigned   idx;
        idx        = int'(req.addr[11:4]);
        r.msg_type = req.msg_type;
        r.opaque   = req.opaque;
        r.len      = req.len;
        r.test     = 2'b00;
        r.data     = '0;
        if (req.msg_type == 3'd0) begin
            r.data = model_mem.exists(idx) ? model_mem[idx] : '0;
        end else if (req.msg_type == 3'd1 || req.msg_type == 3'd2) begin
            model_mem[idx] = req.data;
        end else begin
            r.test = 2'b11;
        end
        return r;
    endfunction

    // Issue one request, wait for its response, compare against scoreboard.
    // hold > 0 keeps memresp_rdy low for that many cycles once valid appears.
    task automatic txn(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                       input logic [3:0] len, input logic [127:0] data, input int hold);
        mem_resp_16B_t exp;
        mem_resp_16B_t snap;
        int            k;
        check("req_rdy_idle", 160'(memreq_rdy), 160'(1));
        memreq_msg.msg_type = t;
        memreq_msg.opaque   = op;
        memreq_msg.addr     = addr;
        memreq_msg.len      = len;
        memreq_msg.data     = data;
        memreq_val          = 1'b1;
        memresp_rdy         = (hold == 0);
        sb_q.push_back(model_resp(memreq_msg));
        @(posedge clk); #1;
        memreq_val = 1'b0;
        k = 0;
        while (!memresp_val && k < 40) begin
            check("req_rdy_wait", 160'(memreq_rdy), 160'(0));
            @(posedge clk); #1;
            k++;
        end
        check("latency", 160'(k), 160'(LAT));
        check("resp_val", 160'(memresp_val), 160'(1));
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check("resp_type",   160'(memresp_msg.msg_type), 160'(exp.msg_type));
            check("resp_opaque", 160'(memresp_msg.opaque),   160'(exp.opaque));
            check("resp_test",   160'(memresp_msg.test),     160'(exp.test));
            check("resp_len",    160'(memresp_msg.len),      160'(exp.len));
            check("resp_data",   160'(memresp_msg.data),     160'(exp.data));
        end
        check("req_rdy_resp", 160'(memreq_rdy), 160'(0));
        if (hold > 0) begin
            snap = memresp_msg;
            repeat (hold) begin
                @(posedge clk); #1;
                check("bp_val",    160'(memresp_val), 160'(1));
                check("bp_stable", 160'(memresp_msg), 160'(snap));
                check("bp_req_rdy", 160'(memreq_rdy), 160'(0));
            end
            memresp_rdy = 1'b1;
        end
        @(posedge clk); #1;
        check("resp_retired", 160'(memresp_val), 160'(0));
        check("req_rdy_back", 160'(memreq_rdy),  160'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        memreq_val  = 1'b0;
        memresp_rdy = 1'b1;
        memreq_msg  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_rdy",  160'(memreq_rdy),  160'(0));
        check("rst_resp_val", 160'(memresp_val), 160'(0));
        reset = 1'b0;
        #1;

        // Init then read
        txn(3'd2, 8'h05, 32'h0000_1000, 4'h0, DATA_D0, 0);
        txn(3'd0, 8'h06, 32'h0000_1000, 4'h0, 128'h0, 0);

        // Write / read / overwrite / read, opaque 0..3
        txn(3'd1, 8'h00, 32'h0000_0020, 4'h0, DATA_A, 0);
        txn(3'd0, 8'h01, 32'h0000_0020, 4'h0, 128'h0, 0);
        txn(3'd1, 8'h02, 32'h0000_0020, 4'h5, DATA_B, 0);
        txn(3'd0, 8'h03, 32'h0000_0020, 4'hf, 128'h0, 0);

        // Backpressure: response held for 5 cycles
        txn(3'd0, 8'h40, 32'h0000_0020, 4'h0, 128'h0, 5);

        // Wrap-around and ignored low bits
        txn(3'd2, 8'h50, 32'h0000_0010, 4'h0, DATA_C, 0);
        txn(3'd0, 8'h51, 32'h0000_1010, 4'h0, 128'h0, 0);
        txn(3'd0, 8'h52, 32'h0000_102f, 4'h3, 128'h0, 0);

        // Unknown types leave the line alone
        txn(3'd3, 8'h60, 32'h0000_0020, 4'h0, DATA_A, 0);
        txn(3'd5, 8'h61, 32'h0000_0020, 4'h0, DATA_C, 0);
        txn(3'd0, 8'h62, 32'h0000_0020, 4'h0, 128'h0, 0);

        // Reset while a read waits: no response ever appears
        memreq_msg.msg_type = 3'd0;
        memreq_msg.opaque   = 8'h70;
        memreq_msg.addr     = 32'h0000_1000;
        memreq_msg.len      = 4'h0;
        memreq_msg.data     = '0;
        memreq_val          = 1'b1;
        @(posedge clk); #1;
        memreq_val = 1'b0;
        check("midwait_req_rdy", 160'(memreq_rdy), 160'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst_val", 160'(memresp_val), 160'(0));
        check("post_rst_rdy", 160'(memreq_rdy),  160'(1));
        repeat (6) begin
            @(posedge clk); #1;
            check("dropped_resp", 160'(memresp_val), 160'(0));
        end

        // Contents survive reset
        txn(3'd0, 8'h71, 32'h0000_0020, 4'h0, 128'h0, 0);
        txn(3'd0, 8'h72, 32'h0000_1000, 4'h0, 128'h0, 0);
        txn(3'd0, 8'h73, 32'h0000_0010, 4'h0, 128'h0, 0);

        check("sb_empty", 160'(sb_q.size()), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
